polygon_area: RTL and testbench
===============================

POLYGON_AREA -- requirements
Module: polygon_area

Interface
REQ-001 Parameter XW, 9, unsigned x-coordinate width in bits.
REQ-002 Parameter YW, 7, unsigned y-coordinate width in bits.
REQ-003 Parameter MAXV, 16, maximum vertices per polygon (>=3).
REQ-004 Derived localparam AW = XW+YW+2+clog2(MAXV), the accumulator and area width.
REQ-005 Port CLOCK_50  in  1  single system clock, all state on rising edge.
REQ-006 Port RESET  in  1  asynchronous, active-high reset.
REQ-007 Port in_valid  in  1  vertex present on in_x/in_y.
REQ-008 Port in_ready  out  1  block accepts a vertex this cycle.
REQ-009 Port in_x  in  XW  vertex x, unsigned.
REQ-010 Port in_y  in  YW  vertex y, unsigned.
REQ-011 Port in_last  in  1  marks the final vertex of the polygon.
REQ-012 Port area  out  AW  twice the polygon area, unsigned: |sum of shoelace cross terms|.
REQ-013 Port out_valid  out  1  area and flags are valid.
REQ-014 Port out_ready  in  1  consumer takes the result.
REQ-015 Port degenerate  out  1  fewer than 3 vertices were received.
REQ-016 Port truncated  out  1  polygon was closed at MAXV without in_last.
REQ-017 Port busy  out  1  high in any state except IDLE.

Function
REQ-018 A vertex SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; no other edge changes vertex state.
REQ-019 FSM states SHALL be IDLE, ACCUM, CLOSE and OUTPUT.
REQ-020 IDLE: in_ready=1; an accept stores the vertex in first and prev, sets count=1 and clears acc; in_last=1 goes to OUTPUT with area=0 and degenerate=1, otherwise the FSM goes to ACCUM.
REQ-021 ACCUM: in_ready=1; each accept SHALL do acc += prev.x*cur.y - cur.x*prev.y (signed, AW bits), prev <= cur and count++.
REQ-022 ACCUM SHALL go to CLOSE on an accept with in_last=1, or on the accept that makes count=MAXV; in the latter case with in_last=0 it SHALL set truncated=1.
REQ-023 CLOSE: in_ready=0; in exactly one cycle, acc += prev.x*first.y - first.x*prev.y, then go to OUTPUT.
REQ-024 OUTPUT: in_ready=0, out_valid=1, area=|acc|, degenerate=(count<3); area is forced to 0 when degenerate.
REQ-025 In OUTPUT, area and flags SHALL hold stable while out_ready=0; an edge with out_ready=1 returns the FSM to IDLE and clears out_valid.
REQ-026 Latency: the last vertex accepted at edge k SHALL give out_valid=1 after edge k+2.
REQ-027 Vertex order (CW/CCW) SHALL NOT affect area; for 3 vertices area SHALL equal |A-B| of the existing triangle formula.
REQ-028 in_valid while in_ready=0 SHALL be ignored and no data SHALL be lost beyond what the handshake permits.

Reset
REQ-029 RESET=1 SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, busy=0, area=0, degenerate=0, truncated=0, count=0, acc=0.
REQ-030 RESET asserted mid-polygon or in OUTPUT SHALL discard the partial result; the first vertex after release starts a new polygon.

Structure
REQ-031 Package polygon_area_pkg SHALL hold the state enumeration, default XW/YW/MAXV and the AW width function.
REQ-032 Sub-module cross_term SHALL compute the signed a.x*b.y - b.x*a.y; it SHALL be instantiated once and muxed between the ACCUM and CLOSE operands.

Verification
REQ-033 Triangle (1,82),(47,1),(47,165), last on 3rd, out_ready=1 -> area=7544, out_valid at edge k+2, flags 0.
REQ-034 Triangle (1,5),(15,25),(3,50) then the same vertices in reverse order -> area=590 both times.
REQ-035 Square (0,0),(10,0),(10,10),(0,10) -> area=200; extreme triangle (0,0),(511,0),(0,127) -> area=64897.
REQ-036 Two vertices (3,3),(9,4) with last -> area=0, degenerate=1; 16 vertices without in_last -> truncated=1 and in_ready=0 after the 16th accept.
REQ-037 out_ready held low 5 cycles in OUTPUT -> area/flags stable, in_ready=0; release -> IDLE next edge.
REQ-038 RESET pulse after 2 of 4 vertices -> out_valid stays 0; a new triangle (1,82),(47,1),(47,165) then gives 7544.

Source files
------------

// File: rtl/polygon_area_pkg.sv
// Shared types, defaults and width helper for the polygon area engine.
package polygon_area_pkg;

  localparam int XW_DEFAULT   = 9;
  localparam int YW_DEFAULT   = 7;
  localparam int MAXV_DEFAULT = 16;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCUM  = 2'd1;
  localparam state_t ST_CLOSE  = 2'd2;
  localparam state_t ST_OUTPUT = 2'd3;

  // Accumulator width: one full cross product, a sign bit, a guard bit,
  // and enough growth bits to sum one term per vertex.
  function automatic int area_width(input int xw, input int yw, input int maxv);
    return xw + yw + 2 + $clog2(maxv);
  endfunction

endpackage

// File: rtl/polygon_area_cross.sv
// Signed shoelace cross term a.x*b.y - b.x*a.y, returned as an AW-bit
// two's complement value ready to add into the accumulator.
module cross_term
  import polygon_area_pkg::*;
#(
  parameter int XW = XW_DEFAULT,
  parameter int YW = YW_DEFAULT,
  parameter int AW = area_width(XW_DEFAULT, YW_DEFAULT, MAXV_DEFAULT)
) (
  input  logic [XW-1:0] a_x,
  input  logic [YW-1:0] a_y,
  input  logic [XW-1:0] b_x,
  input  logic [YW-1:0] b_y,
  output logic [AW-1:0] term
);

  logic [XW+YW-1:0] prod_ab;
  logic [XW+YW-1:0] prod_ba;

  // Both products are non-negative; widen before subtracting so the result wraps correctly
  always_comb begin
    prod_ab = {{YW{1'b0}}, a_x} * {{XW{1'b0}}, b_y};
    prod_ba = {{YW{1'b0}}, b_x} * {{XW{1'b0}}, a_y};
    term    = {{(AW-XW-YW){1'b0}}, prod_ab} - {{(AW-XW-YW){1'b0}}, prod_ba};
  end

endmodule

// File: rtl/polygon_area.sv
// Streaming shoelace engine: accepts polygon vertices one per handshake
// and reports twice the enclosed area once the polygon is closed.
module polygon_area
  import polygon_area_pkg::*;
#(
  parameter int XW   = XW_DEFAULT,
  parameter int YW   = YW_DEFAULT,
  parameter int MAXV = MAXV_DEFAULT,
  localparam int AW  = area_width(XW, YW, MAXV)
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic          in_last,
  output logic [AW-1:0] area,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          degenerate,
  output logic          truncated,
  output logic          busy
);

  localparam int CW = $clog2(MAXV + 1);
  localparam logic [CW-1:0] MAXV_CNT  = CW'(MAXV);
  localparam logic [CW-1:0] MIN_VERTS = CW'(3);

  state_t          state_q,     state_d;
  logic [XW-1:0]   first_x_q,   first_x_d;
  logic [YW-1:0]   first_y_q,   first_y_d;
  logic [XW-1:0]   prev_x_q,    prev_x_d;
  logic [YW-1:0]   prev_y_q,    prev_y_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [AW-1:0]   acc_q,       acc_d;
  logic            trunc_q,     trunc_d;
  logic            degen_q,     degen_d;
  logic [AW-1:0]   area_q,      area_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic [XW-1:0]   b_x;
  logic [YW-1:0]   b_y;
  logic [AW-1:0]   term;
  logic [AW-1:0]   acc_mag;
  logic [CW-1:0]   count_inc;

  assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign area       = area_q;
  assign degenerate = degen_q;
  assign truncated  = trunc_q;

  // Single cross-term unit: new vertex while streaming, first vertex when closing
  always_comb begin
    b_x       = in_x;
    b_y       = in_y;
    if (state_q == ST_CLOSE) begin
      b_x = first_x_q;
      b_y = first_y_q;
    end
    count_inc = count_q + CW'(1);
    acc_mag   = acc_q[AW-1] ? (AW'(0) - acc_q) : acc_q;
  end

  cross_term #(
    .XW (XW),
    .YW (YW),
    .AW (AW)
  ) u_cross (
    .a_x  (prev_x_q),
    .a_y  (prev_y_q),
    .b_x  (b_x),
    .b_y  (b_y),
    .term (term)
  );

  // Controller and datapath next-state
  always_comb begin
    state_d     = state_q;
    first_x_d   = first_x_q;
    first_y_d   = first_y_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    count_d     = count_q;
    acc_d       = acc_q;
    trunc_d     = trunc_q;
    degen_d     = degen_q;
    area_d      = area_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          first_x_d = in_x;
          first_y_d = in_y;
          prev_x_d  = in_x;
          prev_y_d  = in_y;
          count_d   = CW'(1);
          acc_d     = '0;
          trunc_d   = 1'b0;
          state_d   = in_last ? ST_OUTPUT : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          acc_d    = acc_q + term;
          prev_x_d = in_x;
          prev_y_d = in_y;
          count_d  = count_inc;
          if (in_last) begin
            state_d = ST_CLOSE;
          end else if (count_inc == MAXV_CNT) begin
            state_d = ST_CLOSE;
            trunc_d = 1'b1;
          end
        end
      end

      ST_CLOSE: begin
        acc_d   = acc_q + term;
        state_d = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          degen_d     = (count_q < MIN_VERTS);
          area_d      = (count_q < MIN_VERTS) ? '0 : acc_mag;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          area_d      = '0;
          degen_d     = 1'b0;
          trunc_d     = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any polygon in flight
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      first_x_q   <= '0;
      first_y_q   <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      trunc_q     <= 1'b0;
      degen_q     <= 1'b0;
      area_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_x_q   <= first_x_d;
      first_y_q   <= first_y_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      trunc_q     <= trunc_d;
      degen_q     <= degen_d;
      area_q      <= area_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_polygon_area.sv
// Scoreboard bench for polygon_area: directed polygons with hand-computed
// doubled areas, plus handshake, latency, truncation and reset cases.
module tb_polygon_area;
  import polygon_area_pkg::*;

  // y = 165 in the first triangle needs 8 bits, so the y port is widened here
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int MAXV = 16;
  localparam int AW   = area_width(XW, YW, MAXV);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic          in_last;
  logic [AW-1:0] area;
  logic          out_valid;
  logic          out_ready;
  logic          degenerate;
  logic          truncated;
  logic          busy;

  typedef struct {
    int area;
    bit degen;
    bit trunc;
  } exp_t;

  exp_t expq[$];
  int   vx[$];
  int   vy[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  polygon_area #(
    .XW   (XW),
    .YW   (YW),
    .MAXV (MAXV)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_last    (in_last),
    .area       (area),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .degenerate (degenerate),
    .truncated  (truncated),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic sendVertex(input int x, input int y, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_x     = XW'(x);
    in_y     = YW'(y);
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input bit use_last, input int exp_area, input bit exp_degen, input bit exp_trunc);
    exp_t e;
    e.area  = exp_area;
    e.degen = exp_degen;
    e.trunc = exp_trunc;
    expq.push_back(e);
    foreach (vx[i]) sendVertex(vx[i], vy[i], use_last && (i == vx.size() - 1));
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  // Monitor: pops the oldest expectation on every completed output handshake
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_result", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        checkOutput("area",       32'(area),       32'(e.area));
        checkOutput("degenerate", 32'(degenerate), 32'(e.degen));
        checkOutput("truncated",  32'(truncated),  32'(e.trunc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_area",       32'(area),       32'd0);
    checkOutput("rst_degenerate", 32'(degenerate), 32'd0);
    checkOutput("rst_truncated",  32'(truncated),  32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Triangle with latency probe: last vertex at edge k, out_valid after k+2
    vx = '{1, 47, 47};
    vy = '{82, 1, 165};
    applyStimulus(1'b1, 7544, 1'b0, 1'b0);
    checkOutput("t1_in_ready_k",  32'(in_ready),  32'd0);
    checkOutput("t1_out_valid_k", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_out_valid_k1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_out_valid_k2", 32'(out_valid), 32'd1);
    waitIdle("t1_idle");

    // Same triangle in both windings
    vx = '{1, 15, 3};
    vy = '{5, 25, 50};
    applyStimulus(1'b1, 590, 1'b0, 1'b0);
    waitIdle("t2_fwd_idle");
    vx = '{3, 15, 1};
    vy = '{50, 25, 5};
    applyStimulus(1'b1, 590, 1'b0, 1'b0);
    waitIdle("t2_rev_idle");

    // Square and full-range triangle
    vx = '{0, 10, 10, 0};
    vy = '{0, 0, 10, 10};
    applyStimulus(1'b1, 200, 1'b0, 1'b0);
    waitIdle("square_idle");
    vx = '{0, 511, 0};
    vy = '{0, 0, 127};
    applyStimulus(1'b1, 64897, 1'b0, 1'b0);
    waitIdle("extreme_idle");

    // Degenerate: two vertices, then a lone vertex
    vx = '{3, 9};
    vy = '{3, 4};
    applyStimulus(1'b1, 0, 1'b1, 1'b0);
    waitIdle("two_vert_idle");
    vx = '{5};
    vy = '{7};
    applyStimulus(1'b1, 0, 1'b1, 1'b0);
    waitIdle("one_vert_idle");

    // Sixteen vertices without in_last: bottom edge 0..14 then apex (0,10)
    vx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0};
    vy = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  10};
    applyStimulus(1'b0, 140, 1'b0, 1'b1);
    checkOutput("trunc_in_ready", 32'(in_ready), 32'd0);
    checkOutput("trunc_busy",     32'(busy),     32'd1);
    waitIdle("trunc_idle");

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    vx = '{1, 15, 3};
    vy = '{5, 25, 50};
    applyStimulus(1'b1, 590, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      checkOutput("hold_area",      32'(area),       32'd590);
      checkOutput("hold_degen",     32'(degenerate), 32'd0);
      checkOutput("hold_trunc",     32'(truncated),  32'd0);
      checkOutput("hold_in_ready",  32'(in_ready),   32'd0);
      checkOutput("hold_out_valid", 32'(out_valid),  32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_busy",     32'(busy),      32'd0);
    checkOutput("release_in_ready", 32'(in_ready),  32'd1);
    checkOutput("release_valid",    32'(out_valid), 32'd0);

    // Reset mid-polygon discards the partial result
    sendVertex(2, 2, 1'b0);
    sendVertex(30, 2, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy",      32'(busy),      32'd0);
    checkOutput("midrst_area",      32'(area),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("midrst_quiet", 32'(out_valid), 32'd0);
    end
    vx = '{1, 47, 47};
    vy = '{82, 1, 165};
    applyStimulus(1'b1, 7544, 1'b0, 1'b0);
    waitIdle("post_rst_idle");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
